div_unit: RTL

- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits between the register file and the writeback path:
  - consumes the two source-operand read values from the register file;
  - returns a result and destination register address, consumed as write data / write address with a one-cycle write enable.
- Restoring division, one quotient bit per cycle, with a simple start/busy/done handshake.

---
 rtl/div_if.sv | 25 ++
 rtl/div_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/div_if.sv
// Start/busy/done handshake bundle between the issue stage, the divider and writeback.
// The master side issues operations; the slave side (div_unit) returns result and rd_out.
interface div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_addr,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_addr,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip RUN and finish in one cycle.
module div_unit (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int          XLEN       = 32;
  localparam logic [5:0]  COUNT_INIT = 6'(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state, state_nxt;
  logic [5:0]      count;
  logic [XLEN-1:0] dvsr, quo, rem, result_q;
  logic [4:0]      rd_lat, rd_q;
  logic            is_rem, q_neg, r_neg, div_zero, ovf;

  // Decode of the operands presented with start
  logic            in_signed, in_div_zero, in_ovf, early;
  logic [XLEN-1:0] abs_a, abs_b, early_val;
  logic            unused_funct3;

  assign unused_funct3 = bus.funct3[2];
  assign in_signed     = ~bus.funct3[0];
  assign in_div_zero   = (bus.rs2_val == '0);
  assign in_ovf        = in_signed && (bus.rs1_val == INT_MIN) && (bus.rs2_val == '1);
  assign abs_a = (in_signed && bus.rs1_val[XLEN-1]) ? -bus.rs1_val : bus.rs1_val;
  assign abs_b = (in_signed && bus.rs2_val[XLEN-1]) ? -bus.rs2_val : bus.rs2_val;

`ifdef DIV_EARLY_OUT_EN
  assign early = in_div_zero | in_ovf;
`else
  assign early = 1'b0;
`endif

  always_comb begin
    if (bus.funct3[1]) early_val = in_div_zero ? bus.rs1_val : '0;
    else               early_val = in_div_zero ? '1 : INT_MIN;
  end

  // The shifted partial remainder is XLEN+1 bits so a failed trial shows up as the top (borrow) bit.
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix, fin_val;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    diff     = rem_sh - {1'b0, dvsr};
    rem_step = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_step = {quo[XLEN-2:0], ~diff[XLEN]};
    q_fix    = q_neg ? -quo_step : quo_step;
    r_fix    = r_neg ? -rem_step : rem_step;
    if (div_zero) q_fix = '1;
    if (ovf) begin
      q_fix = INT_MIN;
      r_fix = '0;
    end
    fin_val = is_rem ? r_fix : q_fix;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = (state != IDLE);
    bus.done  = (state == FINISH);
    unique case (state)
      IDLE:    if (bus.start) state_nxt = early ? FINISH : RUN;
      RUN:     if (count == 6'd1) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      dvsr     <= '0;
      quo      <= '0;
      rem      <= '0;
      result_q <= '0;
      rd_lat   <= '0;
      rd_q     <= '0;
      is_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          is_rem   <= bus.funct3[1];
          rd_lat   <= bus.rd_addr;
          dvsr     <= abs_b;
          quo      <= abs_a;
          rem      <= '0;
          count    <= COUNT_INIT;
          q_neg    <= in_signed & (bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1]);
          r_neg    <= in_signed & bus.rs1_val[XLEN-1];
          div_zero <= in_div_zero;
          ovf      <= in_ovf;
          if (early) begin
            result_q <= early_val;
            rd_q     <= bus.rd_addr;
          end
        end
        RUN: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count - 6'd1;
          // Final iteration: latch the sign-corrected answer as FINISH is entered
          if (count == 6'd1) begin
            result_q <= fin_val;
            rd_q     <= rd_lat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.rd_out = rd_q;
endmodule
